// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: sync, 3-sample vote, parity/frame/break flags.
// Ports: clk, rst (sync, high), i_rx_serial in; o_rx_dv, o_rx_data, flags, o_busy out.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx_serial,
  output logic                 o_rx_dv,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_busy
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int IW  = $clog2(DATA_BITS);
  localparam int MID = (CLKS_PER_BIT - 1) / 2;

  // cnt_q holds the count being left; a value clocked at the edge
  // where cnt becomes k is the sample "at k". So the three samples
  // land while cnt_q is MID-2, MID-1 and MID, and the decision is
  // registered on the edge where cnt reaches MID+1.
  localparam logic [CW-1:0] S0_AT    = CW'(MID - 2);
  localparam logic [CW-1:0] S1_AT    = CW'(MID - 1);
  localparam logic [CW-1:0] DEC_AT   = CW'(MID);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                 armed_q, armed_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 pbit_q, pbit_d;
  logic                 ferr_q, ferr_d;
  logic                 stop0_low_q, stop0_low_d;
  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 fe_q, fe_d;
  logic                 brk_q, brk_d;

  logic          rxs;
  logic          bit_end;
  logic          dec;
  logic          vote;
  logic [CW-1:0] cnt_nxt;
  logic          first_low;
  logic          par_x;
  logic          perr_c;
  logic          brk_c;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    stop_idx_d  = stop_idx_q;
    armed_d     = armed_q;
    smp_d       = smp_q;
    sh_d        = sh_q;
    pbit_d      = pbit_q;
    ferr_d      = ferr_q;
    stop0_low_d = stop0_low_q;
    dv_d        = 1'b0;
    data_d      = data_q;
    perr_d      = perr_q;
    fe_d        = fe_q;
    brk_d       = brk_q;

    rxs    = sync_q[SYNC_STAGES-1];
    sync_d = {sync_q[SYNC_STAGES-2:0], i_rx_serial};
    // Arming waits until the chain holds real line samples, so a
    // line held low out of reset never looks like a start edge.
    fill_d = {fill_q[SYNC_STAGES-2:0], 1'b1};

    bit_end = (cnt_q == CNT_LAST);
    cnt_nxt = bit_end ? '0 : cnt_q + 1'b1;
    dec     = (cnt_q == DEC_AT);
    vote    = (smp_q[0] & smp_q[1]) |
              (smp_q[0] & rxs) |
              (smp_q[1] & rxs);

    if (cnt_q == S0_AT) smp_d[0] = rxs;
    if (cnt_q == S1_AT) smp_d[1] = rxs;

    first_low = (stop_idx_q == 1'b0) ? ~vote : stop0_low_q;
    par_x     = (^sh_q) ^ pbit_q;
    perr_c    = (PARITY == 1) ? ~par_x :
                (PARITY == 2) ? par_x : 1'b0;
    brk_c     = (sh_q == '0) &&
                ((PARITY == 0) || !pbit_q) &&
                first_low;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rxs && fill_q[SYNC_STAGES-1]) armed_d = 1'b1;
        if (!rxs && armed_q) begin
          state_d     = S_START;
          stop_idx_d  = 1'b0;
          ferr_d      = 1'b0;
          stop0_low_d = 1'b0;
        end
      end
      S_START: begin
        cnt_d = cnt_nxt;
        if (dec && vote) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        cnt_d = cnt_nxt;
        // LSB arrives first, so shifting in at the top leaves
        // each bit at its own index after DATA_BITS shifts.
        if (dec) sh_d = {vote, sh_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_PAR: begin
        cnt_d = cnt_nxt;
        if (dec) pbit_d = vote;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        cnt_d = cnt_nxt;
        if (dec) begin
          if (!vote) ferr_d = 1'b1;
          if (stop_idx_q == 1'b0) stop0_low_d = ~vote;
          // Finish mid-bit on the last stop bit to leave
          // half a bit of margin for a back-to-back start.
          if (stop_idx_q == STOP_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            dv_d    = 1'b1;
            data_d  = brk_c ? '0 : sh_q;
            perr_d  = perr_c;
            fe_d    = ferr_q | ~vote | brk_c;
            brk_d   = brk_c;
            if (brk_c) armed_d = 1'b0;
          end
        end else if (bit_end) begin
          stop_idx_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      stop_idx_q  <= 1'b0;
      sync_q      <= '1;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      smp_q       <= '0;
      sh_q        <= '0;
      pbit_q      <= 1'b0;
      ferr_q      <= 1'b0;
      stop0_low_q <= 1'b0;
      dv_q        <= 1'b0;
      data_q      <= '0;
      perr_q      <= 1'b0;
      fe_q        <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stop_idx_q  <= stop_idx_d;
      sync_q      <= sync_d;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
      smp_q       <= smp_d;
      sh_q        <= sh_d;
      pbit_q      <= pbit_d;
      ferr_q      <= ferr_d;
      stop0_low_q <= stop0_low_d;
      dv_q        <= dv_d;
      data_q      <= data_d;
      perr_q      <= perr_d;
      fe_q        <= fe_d;
      brk_q       <= brk_d;
    end
  end

  assign o_rx_dv      = dv_q;
  assign o_rx_data    = data_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = fe_q;
  assign o_break      = brk_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule
